// File: rtl/sprite_dma_pkg.sv
// sprite_dma_pkg: register map, CTRL/STATUS bit positions and FSM state type for the sprite DMA
package sprite_dma_pkg;
  localparam logic [2:0] DMA_SRC_LO = 3'd0;
  localparam logic [2:0] DMA_SRC_HI = 3'd1;
  localparam logic [2:0] DMA_DST_LO = 3'd2;
  localparam logic [2:0] DMA_DST_HI = 3'd3;
  localparam logic [2:0] DMA_CNT_LO = 3'd4;
  localparam logic [2:0] DMA_CNT_HI = 3'd5;
  localparam logic [2:0] DMA_CTRL   = 3'd6;
  localparam logic [2:0] DMA_STATUS = 3'd7;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ARM    = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int ST_DONE  = 0;
  localparam int ST_ARMED = 6;
  localparam int ST_BUSY  = 7;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_WAIT, S_WRITE, S_RELEASE} dma_state_t;
endpackage

// File: rtl/sprite_dma_regs.sv
// sprite_dma_regs: CPU register file, STATUS read-clear, vblank arming and start/abort decode
//   in : i_clk, i_rst, CPU bus (i_reg_*), i_vblank, i_busy and i_done_set from the engine
//   out: o_reg_dout, programmed o_src/o_dst/o_cnt, o_start_req, o_abort_req, sticky o_irq
module sprite_dma_regs import sprite_dma_pkg::*; #(
  parameter int DST_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_reg_sel,
  input  logic [2:0]       i_reg_addr,
  input  logic             i_reg_wr,
  input  logic             i_reg_rd,
  input  logic [7:0]       i_reg_din,
  output logic [7:0]       o_reg_dout,
  input  logic             i_vblank,
  input  logic             i_busy,
  input  logic             i_done_set,
  output logic [15:0]      o_src,
  output logic [DST_W-1:0] o_dst,
  output logic [8:0]       o_cnt,
  output logic             o_start_req,
  output logic             o_abort_req,
  output logic             o_irq
);
  logic [15:0]      r_src;
  logic [DST_W-1:0] r_dst;
  logic [8:0]       r_cnt;
  logic             r_irq_en, r_armed, r_done, r_irq, r_vbl_q;
  logic             w_cfg_wr, w_ctrl_wr, w_status_rd, w_vbl_rise, w_irq_en;
  logic [15:0]      w_dst16;
  assign w_dst16     = 16'(r_dst);
  assign w_cfg_wr    = i_reg_sel & i_reg_wr & ~i_busy;
  assign w_ctrl_wr   = i_reg_sel & i_reg_wr & (i_reg_addr == DMA_CTRL);
  assign w_status_rd = i_reg_sel & i_reg_rd & (i_reg_addr == DMA_STATUS);
  assign w_vbl_rise  = i_vblank & ~r_vbl_q;
  // an idle CTRL write updates IRQ_EN in the same cycle a zero-length start completes
  assign w_irq_en    = (w_cfg_wr && i_reg_addr == DMA_CTRL) ? i_reg_din[CTRL_IRQ_EN] : r_irq_en;
  assign o_start_req = ~i_busy & ((w_ctrl_wr & i_reg_din[CTRL_START]) | (r_armed & w_vbl_rise));
  assign o_abort_req = i_busy & w_ctrl_wr & i_reg_din[CTRL_ABORT];
  assign o_src = r_src;
  assign o_dst = r_dst;
  assign o_cnt = r_cnt;
  assign o_irq = r_irq;
  assign o_reg_dout = i_reg_addr == DMA_SRC_LO ? r_src[7:0]
                    : i_reg_addr == DMA_SRC_HI ? r_src[15:8]
                    : i_reg_addr == DMA_DST_LO ? w_dst16[7:0]
                    : i_reg_addr == DMA_DST_HI ? w_dst16[15:8]
                    : i_reg_addr == DMA_CNT_LO ? r_cnt[7:0]
                    : i_reg_addr == DMA_CNT_HI ? {7'd0, r_cnt[8]}
                    : i_reg_addr == DMA_CTRL   ? {4'd0, r_irq_en, 3'd0}
                    : {i_busy, r_armed, 5'd0, r_done};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
      r_irq_en <= 1'b0;
      r_armed  <= 1'b0;
      r_done   <= 1'b0;
      r_irq    <= 1'b0;
      r_vbl_q  <= 1'b0;
    end else begin
      r_vbl_q <= i_vblank;
      if (w_cfg_wr && i_reg_addr == DMA_SRC_LO) r_src[7:0]  <= i_reg_din;
      if (w_cfg_wr && i_reg_addr == DMA_SRC_HI) r_src[15:8] <= i_reg_din;
      if (w_cfg_wr && i_reg_addr == DMA_DST_LO) r_dst <= DST_W'({w_dst16[15:8], i_reg_din});
      if (w_cfg_wr && i_reg_addr == DMA_DST_HI) r_dst <= DST_W'({i_reg_din, w_dst16[7:0]});
      if (w_cfg_wr && i_reg_addr == DMA_CNT_LO) r_cnt[7:0] <= i_reg_din;
      if (w_cfg_wr && i_reg_addr == DMA_CNT_HI) r_cnt[8]   <= i_reg_din[0];
      if (w_cfg_wr && i_reg_addr == DMA_CTRL)   r_irq_en   <= i_reg_din[CTRL_IRQ_EN];
      // START together with ARM_VBL runs now and stays armed for the next vblank
      r_armed <= (w_cfg_wr && i_reg_addr == DMA_CTRL && i_reg_din[CTRL_ARM]) || (r_armed && !o_start_req);
      r_done  <= i_done_set | (r_done & ~w_status_rd);
      r_irq   <= (i_done_set & w_irq_en) | (r_irq & ~w_status_rd);
    end
  end
endmodule

// File: rtl/sprite_dma.sv
// sprite_dma: bus-master engine copying CNT bytes from work RAM at SRC into objram at DST
//   in : i_clk, i_rst, CPU register bus (i_reg_*), i_vblank, i_busak_n, i_mem_din
//   out: o_reg_dout, o_busrq_n, o_mem_addr/o_mem_rd, o_obj_addr/o_obj_dout/o_obj_wr, o_dma_active, o_irq
module sprite_dma import sprite_dma_pkg::*; #(
  parameter int MEM_LAT = 1,
  parameter int DST_W   = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_reg_sel,
  input  logic [2:0]       i_reg_addr,
  input  logic             i_reg_wr,
  input  logic             i_reg_rd,
  input  logic [7:0]       i_reg_din,
  output logic [7:0]       o_reg_dout,
  input  logic             i_vblank,
  output logic             o_busrq_n,
  input  logic             i_busak_n,
  output logic [15:0]      o_mem_addr,
  output logic             o_mem_rd,
  input  logic [7:0]       i_mem_din,
  output logic [DST_W-1:0] o_obj_addr,
  output logic [7:0]       o_obj_dout,
  output logic             o_obj_wr,
  output logic             o_dma_active,
  output logic             o_irq
);
  dma_state_t       r_state, w_next;
  logic [15:0]      r_src, w_src;
  logic [DST_W-1:0] r_dst, w_dst;
  logic [8:0]       r_cnt, w_cnt;
  logic [7:0]       r_data, r_wait;
  logic             r_abort, w_abort_req, w_abort, w_start, w_load, w_done_set;
  sprite_dma_regs #(.DST_W(DST_W)) u_regs (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_reg_sel   (i_reg_sel),
    .i_reg_addr  (i_reg_addr),
    .i_reg_wr    (i_reg_wr),
    .i_reg_rd    (i_reg_rd),
    .i_reg_din   (i_reg_din),
    .o_reg_dout  (o_reg_dout),
    .i_vblank    (i_vblank),
    .i_busy      (r_state != S_IDLE),
    .i_done_set  (w_done_set),
    .o_src       (w_src),
    .o_dst       (w_dst),
    .o_cnt       (w_cnt),
    .o_start_req (w_start),
    .o_abort_req (w_abort_req),
    .o_irq       (o_irq)
  );
  assign w_abort    = r_abort | w_abort_req;
  assign w_load     = (r_state == S_IDLE) && w_start && (w_cnt != 9'd0);
  assign w_done_set = ((r_state == S_IDLE) && w_start && (w_cnt == 9'd0)) || (r_state == S_RELEASE);
  assign o_mem_addr = r_src;
  assign o_obj_addr = r_dst;
  assign o_obj_dout = r_data;
  always_ff @(posedge i_clk) begin
    r_state <= i_rst ? S_IDLE : w_next;
  end
  always_comb begin
    w_next       = r_state;
    o_busrq_n    = 1'b1;
    o_mem_rd     = 1'b0;
    o_obj_wr     = 1'b0;
    o_dma_active = 1'b0;
    case (r_state)
      S_IDLE:    w_next = w_load ? S_REQ : S_IDLE;
      S_REQ:     w_next = w_abort ? S_RELEASE : (!i_busak_n ? S_READ : S_REQ);
      S_READ:    w_next = S_WAIT;
      S_WAIT:    w_next = (r_wait == 8'd0) ? S_WRITE : S_WAIT;
      S_WRITE:   w_next = (r_cnt == 9'd1 || w_abort) ? S_RELEASE : S_READ;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    o_busrq_n    = !(r_state inside {S_REQ, S_READ, S_WAIT, S_WRITE});
    o_mem_rd     = r_state == S_READ;
    o_obj_wr     = r_state == S_WRITE;
    o_dma_active = r_state != S_IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_wait  <= '0;
      r_abort <= 1'b0;
    end else begin
      if (w_load) begin
        r_src <= w_src;
        r_dst <= w_dst;
        r_cnt <= w_cnt;
      end
      if (r_state == S_READ) r_wait <= 8'(MEM_LAT - 1);
      if (r_state == S_WAIT) begin
        r_wait <= r_wait - 8'd1;
        if (r_wait == 8'd0) r_data <= i_mem_din;
      end
      if (r_state == S_WRITE) begin
        r_src <= r_src + 16'd1;
        r_dst <= r_dst + 1'b1;
        r_cnt <= r_cnt - 9'd1;
      end
      // abort stays pending until the byte in flight finishes
      r_abort <= (r_state == S_IDLE) ? 1'b0 : (r_abort | w_abort_req);
    end
  end
endmodule

// File: tb/tb_sprite_dma.sv
// tb_sprite_dma: randomized scoreboard bench for sprite_dma against a byte-copy reference model
module tb_sprite_dma;
  logic        clk = 0;
  logic        rst = 1;
  logic        reg_sel = 0, reg_wr = 0, reg_rd = 0, vblank = 0, busak_n = 1;
  logic [2:0]  reg_addr = 0;
  logic [7:0]  reg_din = 0, mem_din = 0;
  logic [7:0]  reg_dout, obj_dout;
  logic        busrq_n, mem_rd, obj_wr, dma_active, irq;
  logic [15:0] mem_addr;
  logic [9:0]  obj_addr;
  logic [7:0]  ram [0:65535];
  logic [17:0] exp_w [$];
  logic [15:0] exp_r [$];
  int checks = 0, errors = 0, cyc = 0, last_wr = -1, wr_count = 0, ack_delay = 4, ack_cnt = 0;
  logic saw_busrq = 0;

  sprite_dma #(.MEM_LAT(1), .DST_W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_reg_sel(reg_sel), .i_reg_addr(reg_addr), .i_reg_wr(reg_wr),
    .i_reg_rd(reg_rd), .i_reg_din(reg_din), .o_reg_dout(reg_dout), .i_vblank(vblank),
    .o_busrq_n(busrq_n), .i_busak_n(busak_n), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .i_mem_din(mem_din), .o_obj_addr(obj_addr), .o_obj_dout(obj_dout), .o_obj_wr(obj_wr),
    .o_dma_active(dma_active), .o_irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd) mem_din <= ram[mem_addr];
  always @(posedge clk) begin
    if (busrq_n) begin
      ack_cnt = 0;
      busak_n <= 1'b1;
    end else begin
      if (ack_cnt >= ack_delay) busak_n <= 1'b0;
      ack_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!busrq_n) saw_busrq = 1;
      if (mem_rd) begin
        if (exp_r.size() == 0) check("mem_rd_unexpected", mem_rd, 0);
        else check("mem_addr", mem_addr, exp_r.pop_front());
      end
      if (obj_wr) begin
        logic [17:0] e;
        wr_count++;
        check("wr_bus_held", busrq_n, 0);
        if (last_wr >= 0) check("wr_gap", cyc - last_wr, 3);
        last_wr = cyc;
        if (exp_w.size() == 0) check("obj_wr_unexpected", obj_wr, 0);
        else begin
          e = exp_w.pop_front();
          check("obj_addr", obj_addr, e[17:8]);
          check("obj_data", obj_dout, e[7:0]);
        end
      end
      if (!dma_active) last_wr = -1;
    end
  end

  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_sel = 1; reg_wr = 1; reg_addr = a; reg_din = d;
    @(negedge clk);
    reg_sel = 0; reg_wr = 0;
  endtask

  task automatic status_read();
    @(negedge clk);
    reg_sel = 1; reg_rd = 1; reg_addr = 3'd7;
    @(negedge clk);
    reg_sel = 0; reg_rd = 0;
  endtask

  task automatic peek(input string name, input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk);
    reg_addr = a;
    #1 check(name, reg_dout, exp);
  endtask

  task automatic setup(input logic [15:0] src, input logic [9:0] dst, input logic [8:0] cnt, input int n_exp);
    reg_write(3'd0, src[7:0]);
    reg_write(3'd1, src[15:8]);
    reg_write(3'd2, dst[7:0]);
    reg_write(3'd3, {6'd0, dst[9:8]});
    reg_write(3'd4, cnt[7:0]);
    reg_write(3'd5, {7'd0, cnt[8]});
    for (int i = 0; i < n_exp; i++) begin
      exp_w.push_back({10'(dst + i), ram[16'(src + i)]});
      exp_r.push_back(16'(src + i));
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!dma_active) break;
    end
    check(name, dma_active, 0);
    check({name, "_wr_left"}, exp_w.size(), 0);
    check({name, "_rd_left"}, exp_r.size(), 0);
    check({name, "_busrq"}, busrq_n, 1);
  endtask

  initial begin
    logic [15:0] s;
    logic [9:0]  d;
    logic [8:0]  n;
    logic        ie;
    bit          hit;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    #1 check("rst_busrq", busrq_n, 1);
    check("rst_outs", {mem_rd, obj_wr, dma_active, irq}, 0);
    check("rst_addr", {mem_addr, obj_addr, obj_dout}, 0);
    rst = 0;
    peek("rst_status", 3'd7, 8'h00);
    peek("rst_src_lo", 3'd0, 8'h00);

    setup(16'h6900, 10'h000, 9'h180, 9'h180);
    reg_write(3'd6, 8'h01);
    reg_write(3'd0, 8'hAA);
    peek("busy_status", 3'd7, 8'h80);
    wait_idle("big_run");
    peek("big_done", 3'd7, 8'h01);
    check("big_no_irq", irq, 0);
    peek("busy_wr_ignored", 3'd0, 8'h00);
    status_read();
    peek("done_cleared", 3'd7, 8'h00);

    saw_busrq = 0;
    reg_write(3'd4, 8'h00);
    reg_write(3'd5, 8'h00);
    reg_write(3'd6, 8'h09);
    #1 check("cnt0_irq", irq, 1);
    peek("cnt0_done", 3'd7, 8'h01);
    repeat (5) @(negedge clk);
    check("cnt0_no_busrq", saw_busrq, 0);
    status_read();
    #1 check("irq_cleared", irq, 0);

    ack_delay = 2;
    setup(16'h1234, 10'h100, 9'd4, 4);
    reg_write(3'd6, 8'h02);
    peek("armed", 3'd7, 8'h40);
    check("armed_idle", dma_active, 0);
    @(negedge clk) vblank = 1;
    @(negedge clk);
    #1 check("vbl_started", dma_active, 1);
    check("vbl_armed_clr", reg_dout[6], 0);
    wait_idle("vbl_run");
    status_read();
    vblank = 0;
    repeat (3) @(negedge clk);
    saw_busrq = 0;
    vblank = 1;
    repeat (6) @(negedge clk);
    check("vbl2_no_run", {saw_busrq, dma_active}, 0);
    vblank = 0;

    setup(16'hFFFE, 10'h3FF, 9'd3, 3);
    reg_write(3'd6, 8'h01);
    wait_idle("wrap_run");
    peek("wrap_done", 3'd7, 8'h01);
    status_read();

    ack_delay = 1;
    setup(16'h4000, 10'h020, 9'd10, 5);
    wr_count = 0;
    reg_write(3'd6, 8'h01);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      hit = (wr_count == 4) && mem_rd;
    end
    check("abort_sync", hit, 1);
    reg_write(3'd6, 8'h04);
    wait_idle("abort_run");
    check("abort_writes", wr_count, 5);
    peek("abort_done", 3'd7, 8'h01);
    status_read();

    for (int r = 0; r < 5; r++) begin
      s = 16'($urandom);
      d = 10'($urandom);
      n = 9'($urandom_range(1, 40));
      ie = 1'($urandom);
      ack_delay = $urandom_range(0, 6);
      setup(s, d, n, int'(n));
      reg_write(3'd6, {4'd0, ie, 3'b001});
      wait_idle("rand_run");
      check("rand_irq", irq, ie);
      peek("rand_done", 3'd7, 8'h01);
      status_read();
    end

    setup(16'h2000, 10'h000, 9'd100, 100);
    reg_write(3'd6, 8'h01);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    exp_w.delete();
    exp_r.delete();
    @(negedge clk);
    @(negedge clk);
    #1 check("midrst_busrq", busrq_n, 1);
    check("midrst_outs", {obj_wr, mem_rd, dma_active}, 0);
    rst = 0;
    peek("midrst_status", 3'd7, 8'h00);
    repeat (20) @(negedge clk);
    check("midrst_idle", dma_active, 0);
    reg_write(3'd0, 8'h55);
    peek("midrst_src_wr", 3'd0, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
